// File: rtl/nlfsr_pkg.sv
// rtl/nlfsr_pkg.sv - shared state type and constants for the NLFSR sequencer
package nlfsr_pkg;

  localparam int REG_W     = 16;
  localparam int TAP_IDX_W = 8;
  localparam logic [TAP_IDX_W-1:0] TAP_IDX_MAX = 8'h0F;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    WARMUP,
    RUN,
    ERROR
  } state_t;

  // A tap index must address a bit of the 16-bit state register
  function automatic logic tap_idx_bad(input logic [TAP_IDX_W-1:0] idx);
    return idx > TAP_IDX_MAX;
  endfunction

endpackage

// File: rtl/nlfsr_cfg_loader.sv
// rtl/nlfsr_cfg_loader.sv - byte-serial tap/seed loader with range check
module nlfsr_cfg_loader
  import nlfsr_pkg::*;
#(
  parameter int NUM_OF_TAPS = 15
)
(
  input  logic                             clk,
  input  logic                             res,
  input  logic                             accept,
  input  logic                             first,
  input  logic [TAP_IDX_W-1:0]             data,
  output logic [NUM_OF_TAPS*TAP_IDX_W-1:0] co_buf,
  output logic [REG_W-1:0]                 seed,
  output logic                             done,
  output logic                             bad
);

  localparam int IDX_W = $clog2(NUM_OF_TAPS + 2);
  localparam logic [IDX_W-1:0] SEED_LO = IDX_W'(NUM_OF_TAPS);
  localparam logic [IDX_W-1:0] SEED_HI = IDX_W'(NUM_OF_TAPS + 1);

  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             bad_acc;
  logic             tap_err;

  // The first byte of a load always lands at index 0, whatever the counter holds
  assign idx     = first ? '0 : cnt;
  assign tap_err = (idx < SEED_LO) && tap_idx_bad(data);
  assign done    = accept && (idx == SEED_HI);
  // Evaluated on the seed MSB: any earlier bad tap, or an all-zero seed
  assign bad     = bad_acc || ({data, seed[TAP_IDX_W-1:0]} == '0);

  // Capture each accepted byte into its tap slot or seed half
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt     <= '0;
      bad_acc <= 1'b0;
      co_buf  <= '0;
      seed    <= '0;
    end else if (accept) begin
      cnt     <= idx + 1'b1;
      bad_acc <= (first ? 1'b0 : bad_acc) | tap_err;
      for (int i = 0; i < NUM_OF_TAPS; i++) begin
        if (idx == IDX_W'(i)) co_buf[i*TAP_IDX_W +: TAP_IDX_W] <= data;
      end
      if (idx == SEED_LO) seed[TAP_IDX_W-1:0]     <= data;
      if (idx == SEED_HI) seed[REG_W-1:TAP_IDX_W] <= data;
    end
  end

endmodule

// File: rtl/nlfsr_ctrl.sv
// rtl/nlfsr_ctrl.sv - NLFSR sequencer top; NLFSR_CTRL_PERIOD_CHECK_EN adds period_hit/period_len
module nlfsr_ctrl
  import nlfsr_pkg::*;
#(
  parameter int NUM_OF_TAPS  = 15,
  parameter int WARMUP_STEPS = 32,
  parameter int CNT_W        = 16
)
(
  input  logic                             clk,
  input  logic                             res,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [TAP_IDX_W-1:0]             cfg_data,
  input  logic                             start,
  input  logic                             stop,
  output logic [NUM_OF_TAPS*TAP_IDX_W-1:0] co_buf,
  output logic [REG_W-1:0]                 nlfsr_reg,
  output logic                             taps_clr,
  input  logic                             fb_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_bit,
  output logic                             busy,
  output logic                             err
`ifdef NLFSR_CTRL_PERIOD_CHECK_EN
  ,
  output logic                             period_hit,
  output logic [CNT_W-1:0]                 period_len
`endif
);

  localparam logic [CNT_W-1:0] WARM_LAST =
    CNT_W'((WARMUP_STEPS > 0) ? WARMUP_STEPS - 1 : 0);

  state_t           state;
  logic             phase_b;
  logic             cfg_loaded;
  logic [CNT_W-1:0] warm_cnt;
  logic             ld_accept;
  logic             ld_first;
  logic             ld_done;
  logic             ld_bad;
  logic [REG_W-1:0] seed;
  logic [REG_W-1:0] step_val;

  // Bytes are taken in IDLE (as tap 1) and LOAD; a stop aborts without consuming
  assign ld_first  = (state == IDLE);
  assign ld_accept = cfg_valid && !stop && ((state == IDLE) || (state == LOAD));
  assign step_val  = {fb_in, nlfsr_reg[REG_W-1:1]};
  assign out_bit   = nlfsr_reg[0];

  nlfsr_cfg_loader #(
    .NUM_OF_TAPS(NUM_OF_TAPS)
  ) u_loader (
    .clk    (clk),
    .res    (res),
    .accept (ld_accept),
    .first  (ld_first),
    .data   (cfg_data),
    .co_buf (co_buf),
    .seed   (seed),
    .done   (ld_done),
    .bad    (ld_bad)
  );

  // Main sequencer: load, clear, warm-up and handshaked keystream run
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state      <= IDLE;
      phase_b    <= 1'b0;
      warm_cnt   <= '0;
      nlfsr_reg  <= '0;
      cfg_ready  <= 1'b0;
      taps_clr   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      cfg_loaded <= 1'b0;
    end else if (stop && busy) begin
      state     <= IDLE;
      phase_b   <= 1'b0;
      cfg_ready <= 1'b0;
      taps_clr  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (stop) begin
            state <= IDLE;
          end else if (cfg_valid) begin
            state      <= LOAD;
            cfg_ready  <= 1'b1;
            busy       <= 1'b1;
            cfg_loaded <= 1'b0;
          end else if (start && cfg_loaded) begin
            state <= CLEAR;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (ld_done) begin
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            if (ld_bad) begin
              state <= ERROR;
              err   <= 1'b1;
            end else begin
              state      <= IDLE;
              cfg_loaded <= 1'b1;
            end
          end
        end
        CLEAR: begin
          nlfsr_reg <= seed;
          phase_b   <= 1'b0;
          warm_cnt  <= '0;
          taps_clr  <= 1'b0;
          state     <= (WARMUP_STEPS == 0) ? RUN : WARMUP;
        end
        WARMUP: begin
          if (!phase_b) begin
            phase_b <= 1'b1;
          end else begin
            nlfsr_reg <= step_val;
            phase_b   <= 1'b0;
            if (warm_cnt == WARM_LAST) state <= RUN;
            else warm_cnt <= warm_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!phase_b) begin
            phase_b   <= 1'b1;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            nlfsr_reg <= step_val;
            phase_b   <= 1'b0;
            out_valid <= 1'b0;
          end
        end
        ERROR: begin
          if (stop) begin
            state      <= IDLE;
            err        <= 1'b0;
            cfg_loaded <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NLFSR_CTRL_PERIOD_CHECK_EN
  logic [CNT_W-1:0] run_steps;
  logic [CNT_W-1:0] steps_next;
  logic             run_step;

  assign run_step   = (state == RUN) && phase_b && out_ready && !stop;
  assign steps_next = (run_steps == '1) ? run_steps : run_steps + 1'b1;

  // Count RUN steps until the state comes back to the seed; saturate otherwise
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      run_steps  <= '0;
      period_hit <= 1'b0;
      period_len <= '0;
    end else if (state == CLEAR) begin
      run_steps  <= '0;
      period_hit <= 1'b0;
      period_len <= '0;
    end else if (run_step && !period_hit) begin
      run_steps <= steps_next;
      if (step_val == seed) begin
        period_hit <= 1'b1;
        period_len <= steps_next;
      end else if (steps_next == '1) begin
        period_len <= '1;
      end
    end
  end
`endif

endmodule
